// File: rtl/j1b_uart_ctl.sv
// j1b_uart_ctl: j1b IO-bus UART controller with TX/RX FIFOs; define J1B_UART_LOOPBACK_EN for TX->RX loopback via 0x2004
module j1b_uart_ctl #(
   parameter int TX_AW = 4,
   parameter int RX_AW = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_strobe,
   input  logic [7:0]  rx_data
);
   logic [7:0] tx_mem [2**TX_AW];
   logic [7:0] rx_mem [2**RX_AW];
   logic [TX_AW:0] tx_wp, tx_rp;
   logic [RX_AW:0] rx_wp, rx_rp;
   logic rx_overrun, tx_drop, loopback, lb_move;
   logic sel_data, sel_stat, tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, rx_req, ovr_set, drop_set, stat_rd;
   logic [7:0] rx_head, rx_in;
   logic [31:0] ctl_rd;
   logic unused_wdata;

   assign unused_wdata = ^io_wdata[31:8];
   assign sel_data = io_addr == 16'h1000;
   assign sel_stat = io_addr == 16'h2000;
   assign tx_empty = tx_wp == tx_rp;
   assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) && (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
   assign rx_empty = rx_wp == rx_rp;
   assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) && (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);

   assign tx_data  = tx_empty ? 8'd0 : tx_mem[tx_rp[TX_AW-1:0]];
   assign rx_head  = rx_empty ? 8'd0 : rx_mem[rx_rp[RX_AW-1:0]];
   assign tx_valid = !tx_empty && !loopback;

   // In loopback the TX head feeds the RX FIFO and the external receiver is ignored
   assign lb_move  = loopback && !tx_empty && !rx_full;
   assign tx_push  = io_wr && sel_data && !tx_full;
   assign drop_set = io_wr && sel_data && tx_full;
   assign tx_pop   = loopback ? lb_move : tx_valid && tx_ready;
   assign rx_pop   = io_rd && sel_data && !rx_empty;
   assign rx_req   = loopback ? lb_move : rx_strobe;
   assign rx_in    = loopback ? tx_data : rx_data;
   // A same-cycle pop frees the slot, so a strobe into a full FIFO is still accepted
   assign rx_push  = rx_req && (!rx_full || rx_pop);
   assign ovr_set  = rx_req && rx_full && !rx_pop;
   assign stat_rd  = io_rd && sel_stat;

`ifdef J1B_UART_LOOPBACK_EN
   logic sel_ctl;
   assign sel_ctl = io_addr == 16'h2004;
   assign ctl_rd  = sel_ctl ? {31'd0, loopback} : 32'd0;
   always_ff @(posedge clk)
      if (reset) loopback <= 1'b0;
      else if (io_wr && sel_ctl) loopback <= io_wdata[0];
`else
   assign loopback = 1'b0;
   assign ctl_rd   = 32'd0;
`endif

   assign io_rdata = sel_data ? {24'd0, rx_head} :
                     sel_stat ? {27'd0, tx_drop, rx_overrun, tx_empty, !rx_empty, !tx_full} : ctl_rd;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= io_wdata[7:0];
      if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_in;
   end

   // Status read clears the sticky flags unless a new event sets them in the same cycle
   always_ff @(posedge clk)
      if (reset) begin
         tx_wp      <= '0;
         tx_rp      <= '0;
         rx_wp      <= '0;
         rx_rp      <= '0;
         rx_overrun <= 1'b0;
         tx_drop    <= 1'b0;
      end else begin
         tx_wp      <= tx_push ? tx_wp + (TX_AW+1)'(1) : tx_wp;
         tx_rp      <= tx_pop ? tx_rp + (TX_AW+1)'(1) : tx_rp;
         rx_wp      <= rx_push ? rx_wp + (RX_AW+1)'(1) : rx_wp;
         rx_rp      <= rx_pop ? rx_rp + (RX_AW+1)'(1) : rx_rp;
         rx_overrun <= ovr_set || (rx_overrun && !stat_rd);
         tx_drop    <= drop_set || (tx_drop && !stat_rd);
      end
endmodule
